// File: rtl/che_packet_tx.sv
// CHE advertisement transmitter.
// On a start pulse in idle, the block captures the node's ID, hop count (+1, saturating) and
// Q-value. It then waits a backoff taken from the node ID and streams a 5-word packet on a
// valid/ready interface: type, ID, hops, Q-value, XOR checksum.
// A heartbeat reset aborts the packet at any point.
module che_packet_tx #(
  parameter int unsigned               WORD_WIDTH   = 16,
  parameter logic [WORD_WIDTH-1:0]     PKT_TYPE_CHE = 16'h0002,
  parameter int unsigned               BO_BITS      = 4
) (
  input  logic                  clk,
  input  logic                  nrst,
  input  logic                  en_CHE,
  input  logic                  HB_reset,
  input  logic [WORD_WIDTH-1:0] myNodeID,
  input  logic [WORD_WIDTH-1:0] myHops,
  input  logic [WORD_WIDTH-1:0] myQValue,
  input  logic                  tx_ready,
  output logic [WORD_WIDTH-1:0] tx_data,
  output logic                  tx_valid,
  output logic                  tx_last,
  output logic                  busy,
  output logic                  done
);

  typedef enum logic [1:0] {StIdle, StBackoff, StSend, StDone} state_e;

  state_e                r_state;
  logic [2:0]            r_idx;
  logic [BO_BITS-1:0]    r_cnt;
  logic [WORD_WIDTH-1:0] r_id;
  logic [WORD_WIDTH-1:0] r_hops;
  logic [WORD_WIDTH-1:0] r_q;

  state_e                w_state_nxt;
  logic [2:0]            w_idx_nxt;
  logic [BO_BITS-1:0]    w_cnt_nxt;
  logic [WORD_WIDTH-1:0] w_id_nxt;
  logic [WORD_WIDTH-1:0] w_hops_nxt;
  logic [WORD_WIDTH-1:0] w_q_nxt;
  logic [WORD_WIDTH-1:0] w_hops_inc;
  logic [WORD_WIDTH-1:0] w_csum;
  logic [WORD_WIDTH-1:0] w_word;
  logic                  w_fire;

  // Hop count advertised is one more than ours, pinned at all-ones.
  assign w_hops_inc = (myHops == '1) ? myHops : myHops + WORD_WIDTH'(1);
  assign w_csum     = PKT_TYPE_CHE ^ r_id ^ r_hops ^ r_q;
  assign w_fire     = (r_state == StSend) && tx_ready;

  // Select the packet word for the current index.
  always_comb begin
    w_word = '0;
    unique case (r_idx)
      3'd0:    w_word = PKT_TYPE_CHE;
      3'd1:    w_word = r_id;
      3'd2:    w_word = r_hops;
      3'd3:    w_word = r_q;
      3'd4:    w_word = w_csum;
      default: w_word = '0;
    endcase
  end

  // Next-state logic; heartbeat reset overrides everything, including a completing handshake.
  always_comb begin
    w_state_nxt = r_state;
    w_idx_nxt   = r_idx;
    w_cnt_nxt   = r_cnt;
    w_id_nxt    = r_id;
    w_hops_nxt  = r_hops;
    w_q_nxt     = r_q;
    unique case (r_state)
      StIdle: begin
        if (en_CHE) begin
          w_id_nxt    = myNodeID;
          w_hops_nxt  = w_hops_inc;
          w_q_nxt     = myQValue;
          w_cnt_nxt   = myNodeID[BO_BITS-1:0];
          w_idx_nxt   = '0;
          w_state_nxt = StBackoff;
        end
      end
      StBackoff: begin
        if (r_cnt != '0) begin
          w_cnt_nxt = r_cnt - BO_BITS'(1);
        end else begin
          w_state_nxt = StSend;
        end
      end
      StSend: begin
        if (w_fire) begin
          if (r_idx == 3'd4) begin
            w_idx_nxt   = '0;
            w_state_nxt = StDone;
          end else begin
            w_idx_nxt = r_idx + 3'd1;
          end
        end
      end
      StDone: begin
        w_state_nxt = StIdle;
      end
      default: begin
        w_state_nxt = StIdle;
      end
    endcase
    if (HB_reset) begin
      w_state_nxt = StIdle;
      w_idx_nxt   = '0;
      w_cnt_nxt   = '0;
    end
  end

  // State and capture registers.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      r_state <= StIdle;
      r_idx   <= '0;
      r_cnt   <= '0;
      r_id    <= '0;
      r_hops  <= '0;
      r_q     <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_idx   <= w_idx_nxt;
      r_cnt   <= w_cnt_nxt;
      r_id    <= w_id_nxt;
      r_hops  <= w_hops_nxt;
      r_q     <= w_q_nxt;
    end
  end

  // Outputs decode directly from state, so an async reset clears them at once.
  always_comb begin
    tx_valid = (r_state == StSend);
    tx_data  = tx_valid ? w_word : '0;
    tx_last  = tx_valid && (r_idx == 3'd4);
    busy     = (r_state == StBackoff) || (r_state == StSend);
    done     = (r_state == StDone);
  end

endmodule

// File: tb/tb_che_packet_tx.sv
// Directed bench for che_packet_tx: one task per scenario, inline comparisons.
module tb_che_packet_tx;

  logic        clk = 1'b0;
  logic        nrst;
  logic        en_CHE;
  logic        HB_reset;
  logic [15:0] myNodeID;
  logic [15:0] myHops;
  logic [15:0] myQValue;
  logic        tx_ready;
  logic [15:0] tx_data;
  logic        tx_valid;
  logic        tx_last;
  logic        busy;
  logic        done;

  int n_cmp = 0;
  int n_err = 0;

  che_packet_tx dut (
    .clk      (clk),
    .nrst     (nrst),
    .en_CHE   (en_CHE),
    .HB_reset (HB_reset),
    .myNodeID (myNodeID),
    .myHops   (myHops),
    .myQValue (myQValue),
    .tx_ready (tx_ready),
    .tx_data  (tx_data),
    .tx_valid (tx_valid),
    .tx_last  (tx_last),
    .busy     (busy),
    .done     (done)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Pulse en_CHE across one rising edge (E0); returns 1 time unit after E0.
  task automatic start_pkt(input logic [15:0] id, input logic [15:0] hops, input logic [15:0] q);
    myNodeID = id;
    myHops   = hops;
    myQValue = q;
    en_CHE   = 1'b1;
    tick();
    en_CHE   = 1'b0;
  endtask

  // Advance until tx_valid is seen (bounded); lat = edges after E0.
  task automatic wait_valid(output int lat);
    lat = 0;
    while (tx_valid !== 1'b1 && lat < 40) begin
      tick();
      lat++;
    end
  endtask

  task automatic test_reset();
    nrst = 1'b0; en_CHE = 1'b0; HB_reset = 1'b0; tx_ready = 1'b0;
    myNodeID = '0; myHops = '0; myQValue = '0;
    tick(); tick();
    n_cmp++;
    if ({tx_data, tx_valid, tx_last, busy, done} !== 20'h0) begin
      n_err++;
      $display("FAIL reset_outputs: got %h/%b%b%b%b want 0000/0000",
               tx_data, tx_valid, tx_last, busy, done);
    end
    #3 nrst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      n_cmp++;
      if ({tx_valid, busy, done} !== 3'b000) begin
        n_err++;
        $display("FAIL reset_idle%0d: got v/b/d=%b%b%b want 000", i, tx_valid, busy, done);
      end
    end
  endtask

  task automatic test_basic();
    logic [15:0] exp [5] = '{16'h0002, 16'h000C, 16'h0001, 16'h4000, 16'h400F};
    int lat;
    tx_ready = 1'b1;
    start_pkt(16'd12, 16'd0, 16'h4000);
    n_cmp++;
    if ({busy, tx_valid} !== 2'b10) begin
      n_err++;
      $display("FAIL basic_busy_after_start: got busy/valid=%b%b want 10", busy, tx_valid);
    end
    wait_valid(lat);
    n_cmp++;
    if (lat != 13) begin
      n_err++;
      $display("FAIL basic_latency: got %0d want 13", lat);
    end
    for (int i = 0; i < 5; i++) begin
      n_cmp++;
      if ({tx_valid, tx_last, tx_data} !== {1'b1, (i == 4), exp[i]}) begin
        n_err++;
        $display("FAIL basic_word%0d: got v=%b l=%b %h want v=1 l=%b %h",
                 i, tx_valid, tx_last, tx_data, (i == 4), exp[i]);
      end
      tick();
    end
    n_cmp++;
    if ({done, busy, tx_valid, tx_last} !== 4'b1000) begin
      n_err++;
      $display("FAIL basic_done: got d/b/v/l=%b%b%b%b want 1000", done, busy, tx_valid, tx_last);
    end
    tick();
    n_cmp++;
    if ({done, busy} !== 2'b00) begin
      n_err++;
      $display("FAIL basic_done_once: got d/b=%b%b want 00", done, busy);
    end
  endtask

  task automatic test_stall();
    logic [15:0] exp [5] = '{16'h0002, 16'h0010, 16'h0003, 16'h3000, 16'h3011};
    int lat;
    tx_ready = 1'b0;
    start_pkt(16'd16, 16'd2, 16'h3000);
    wait_valid(lat);
    n_cmp++;
    if (lat != 1) begin
      n_err++;
      $display("FAIL stall_latency: got %0d want 1", lat);
    end
    for (int i = 0; i < 5; i++) begin
      tx_ready = 1'b0;
      tick();
      n_cmp++;
      if ({tx_valid, tx_last, tx_data} !== {1'b1, (i == 4), exp[i]}) begin
        n_err++;
        $display("FAIL stall_hold%0d: got v=%b l=%b %h want v=1 l=%b %h",
                 i, tx_valid, tx_last, tx_data, (i == 4), exp[i]);
      end
      tx_ready = 1'b1;
      tick();
    end
    n_cmp++;
    if ({done, busy, tx_valid} !== 3'b100) begin
      n_err++;
      $display("FAIL stall_done: got d/b/v=%b%b%b want 100", done, busy, tx_valid);
    end
    tick();
  endtask

  task automatic test_saturate();
    logic [15:0] exp [5] = '{16'h0002, 16'h0017, 16'hFFFF, 16'h2000, 16'hDFEA};
    int lat;
    tx_ready = 1'b1;
    start_pkt(16'd23, 16'hFFFF, 16'h2000);
    wait_valid(lat);
    n_cmp++;
    if (lat != 8) begin
      n_err++;
      $display("FAIL sat_latency: got %0d want 8", lat);
    end
    for (int i = 0; i < 5; i++) begin
      n_cmp++;
      if (tx_data !== exp[i]) begin
        n_err++;
        $display("FAIL sat_word%0d: got %h want %h", i, tx_data, exp[i]);
      end
      tick();
    end
    n_cmp++;
    if (done !== 1'b1) begin
      n_err++;
      $display("FAIL sat_done: got %b want 1", done);
    end
    tick();
  endtask

  task automatic test_hb_abort();
    logic [15:0] exp [5] = '{16'h0002, 16'h0001, 16'h0006, 16'h1234, 16'h1231};
    int lat;
    tx_ready = 1'b1;
    start_pkt(16'd1, 16'd5, 16'h1234);
    wait_valid(lat);
    tick(); tick();
    n_cmp++;
    if (tx_data !== 16'h0006) begin
      n_err++;
      $display("FAIL hb_word2: got %h want 0006", tx_data);
    end
    HB_reset = 1'b1;
    tick();
    HB_reset = 1'b0;
    n_cmp++;
    if ({done, busy, tx_valid, tx_last} !== 4'b0000) begin
      n_err++;
      $display("FAIL hb_abort: got d/b/v/l=%b%b%b%b want 0000", done, busy, tx_valid, tx_last);
    end
    tick();
    n_cmp++;
    if ({done, busy} !== 2'b00) begin
      n_err++;
      $display("FAIL hb_no_done: got d/b=%b%b want 00", done, busy);
    end
    start_pkt(16'd1, 16'd5, 16'h1234);
    wait_valid(lat);
    n_cmp++;
    if (lat != 2) begin
      n_err++;
      $display("FAIL hb_restart_latency: got %0d want 2", lat);
    end
    for (int i = 0; i < 5; i++) begin
      n_cmp++;
      if (tx_data !== exp[i]) begin
        n_err++;
        $display("FAIL hb_restart_word%0d: got %h want %h", i, tx_data, exp[i]);
      end
      tick();
    end
    n_cmp++;
    if (done !== 1'b1) begin
      n_err++;
      $display("FAIL hb_restart_done: got %b want 1", done);
    end
    tick();
  endtask

  task automatic test_ignore_start();
    logic [15:0] exp [5] = '{16'h0002, 16'h0003, 16'h0008, 16'h0400, 16'h0409};
    int lat;
    tx_ready = 1'b1;
    start_pkt(16'd3, 16'd7, 16'h0400);
    myNodeID = 16'h00FF;
    en_CHE   = 1'b1;
    tick();
    en_CHE   = 1'b0;
    wait_valid(lat);
    for (int i = 0; i < 5; i++) begin
      n_cmp++;
      if (tx_data !== exp[i]) begin
        n_err++;
        $display("FAIL ign_word%0d: got %h want %h", i, tx_data, exp[i]);
      end
      en_CHE = (i == 1);
      if (i == 1) myNodeID = 16'h0AAA;
      tick();
    end
    en_CHE = 1'b0;
    n_cmp++;
    if ({done, busy} !== 2'b10) begin
      n_err++;
      $display("FAIL ign_done: got d/b=%b%b want 10", done, busy);
    end
    en_CHE = 1'b1;
    tick();
    en_CHE = 1'b0;
    n_cmp++;
    if ({done, busy, tx_valid} !== 3'b000) begin
      n_err++;
      $display("FAIL ign_start_in_done: got d/b/v=%b%b%b want 000", done, busy, tx_valid);
    end
    tick();
    n_cmp++;
    if ({done, busy} !== 2'b00) begin
      n_err++;
      $display("FAIL ign_single_done: got d/b=%b%b want 00", done, busy);
    end
  endtask

  task automatic test_async_reset();
    int lat;
    tx_ready = 1'b1;
    start_pkt(16'd0, 16'd9, 16'h0055);
    wait_valid(lat);
    tick();
    n_cmp++;
    if ({tx_valid, tx_data} !== {1'b1, 16'h0000}) begin
      n_err++;
      $display("FAIL arst_word1: got v=%b %h want v=1 0000", tx_valid, tx_data);
    end
    #1 nrst = 1'b0;
    #1;
    n_cmp++;
    if ({tx_data, tx_valid, tx_last, busy, done} !== 20'h0) begin
      n_err++;
      $display("FAIL arst_immediate: got %h/%b%b%b%b want 0000/0000",
               tx_data, tx_valid, tx_last, busy, done);
    end
    #2 nrst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      n_cmp++;
      if ({tx_valid, busy, done} !== 3'b000) begin
        n_err++;
        $display("FAIL arst_idle%0d: got v/b/d=%b%b%b want 000", i, tx_valid, busy, done);
      end
    end
    start_pkt(16'd2, 16'd0, 16'h0000);
    n_cmp++;
    if (busy !== 1'b1) begin
      n_err++;
      $display("FAIL arst_restart_busy: got %b want 1", busy);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_stall();
    test_saturate();
    test_hb_abort();
    test_ignore_start();
    test_async_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/che_packet_tx.md
Name: che_packet_tx

Overview:
Transmit side of the cluster-head election (CHE) advertisement that the known-CH table consumes (fCH_ID / fCH_Hops / fCH_QValue).
- When a node is elected CH, it serialises its own ID, hop count and Q-value into a 5-word, 16-bit packet on a valid/ready stream towards the radio/MAC.
- Before sending, it applies a per-node deterministic backoff to reduce broadcast collisions.
- A heartbeat reset aborts any packet in flight.

Parameters:
WORD_WIDTH, 16, width of every packet word and data input
PKT_TYPE_CHE, 16'h0002, constant header word identifying a CHE packet
BO_BITS, 4, number of low nodeID bits used as backoff length in cycles (0..2^BO_BITS-1)

Ports:
clk  input  1  system clock, rising edge
nrst  input  1  asynchronous active-low reset
en_CHE  input  1  start pulse; sampled only in IDLE
HB_reset  input  1  synchronous abort/clear (heartbeat received)
myNodeID  input  WORD_WIDTH  own node ID, captured at start
myHops  input  WORD_WIDTH  own hops-to-sink, captured at start
myQValue  input  WORD_WIDTH  own Q-value (Q2.14, 16'h4000 = 1.0), captured at start
tx_ready  input  1  downstream can accept a word this cycle
tx_data  output  WORD_WIDTH  current packet word
tx_valid  output  1  tx_data valid
tx_last  output  1  high with word 4 (checksum)
busy  output  1  packet pending or in flight
done  output  1  one-cycle pulse after successful final transfer

Behaviour:
- Interface: one clock (clk); reset nrst is asynchronous, active-low. All other state changes on rising clk.
- Reset values: tx_data=0, tx_valid=0, tx_last=0, busy=0, done=0, FSM=IDLE, word index=0, backoff counter=0, captured registers=0.
- FSM states: IDLE, BACKOFF, SEND, DONE.
- IDLE:
  - On en_CHE=1 at edge E0, capture myNodeID, myQValue and hops_tx.
  - hops_tx = myHops+1, saturating at 16'hFFFF; myHops=16'hFFFF stays 16'hFFFF.
  - Load counter with myNodeID[BO_BITS-1:0]; go to BACKOFF.
  - busy=1 from the cycle after E0.
- BACKOFF:
  - Counter nonzero: decrement each cycle.
  - Counter zero: go to SEND.
  - Net latency: tx_valid first high N+1 cycles after E0, where N = backoff value. N=0 gives tx_valid high the cycle after E0.
- SEND:
  - tx_valid=1; tx_data=word[idx] for idx 0..4.
  - Words: 0=PKT_TYPE_CHE, 1=nodeID, 2=hops_tx, 3=QValue, 4=XOR of words 0..3.
  - tx_last=1 only for idx=4.
  - idx advances only on tx_valid && tx_ready. tx_data is held stable while tx_ready=0; stalls of any length are legal.
  - Full throughput: 5 words in 5 consecutive cycles when tx_ready is held high.
- DONE:
  - Entered after the idx=4 handshake. tx_valid=0, tx_last=0, busy=0, done=1 for exactly one cycle.
  - Return to IDLE.
  - An en_CHE asserted during DONE is ignored; a new start is possible from the following cycle.
- en_CHE outside IDLE is ignored; no queuing.
- Input changes after capture do not affect the packet in flight.
- HB_reset=1 in any state: next cycle FSM=IDLE, tx_valid=0, tx_last=0, busy=0, idx=0, counter=0; done is NOT pulsed.
  - HB_reset has priority over en_CHE and over a handshake completing in the same cycle; that word counts as not sent.
- nrst low mid-packet: outputs go to reset values immediately (asynchronously).
- Checksum is a plain 16-bit XOR; no carry or width growth.

Test Plan:
1. Reset, then en_CHE pulse with myNodeID=16'd12, myHops=0, myQValue=16'h4000, tx_ready=1 -> tx_valid rises 13 cycles after start. Words in consecutive cycles: 0002, 000C, 0001, 4000, 400F (tx_last on 400F); done pulses once; busy falls with done.
2. myNodeID=16'd16 (backoff 0), myHops=16'd2, myQValue=16'h3000, tx_ready toggling 1/0 -> tx_valid the cycle after start. Words 0002, 0010, 0003, 3000, 3011, each held stable through every stall.
3. myHops=16'hFFFF, myNodeID=16'd23, myQValue=16'h2000 -> hops word = FFFF (saturated); checksum = 0002^0017^FFFF^2000 = DFEA.
4. Start packet, then assert HB_reset while idx=2 with tx_ready=1 -> next cycle tx_valid=0, busy=0, no done. A new en_CHE afterwards sends a complete packet from word 0.
5. Second en_CHE during BACKOFF and during SEND with changed myNodeID -> ignored; the packet carries the originally captured ID; exactly one done pulse.
6. Drive nrst low during SEND -> all outputs zero immediately; after release the block idles until en_CHE.
